// File: rtl/relay_coil_driver.sv
// relay_coil_driver: drives a bank of N relay coils from a valid/ready request,
// waits the mechanical pull-in / drop-out time, then samples contact feedback
// and reports completion with a one-cycle done pulse.
// Optional feature macro: RELAY_FB_CHECK_EN
//   defined   -> contact feedback is synchronized and compared against the coils
//   undefined -> feedback ignored, settled_state mirrors coil_drv, err stays 0
module relay_coil_driver #(
   parameter int N            = 8,
   parameter int PULL_IN_CYC  = 20,
   parameter int DROP_OUT_CYC = 12,
   parameter int CNT_W        = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] req_coils,
   output logic [N-1:0] coil_drv,
   input  logic [N-1:0] contact_fb,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] settled_state,
   output logic         err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;

   localparam int MAX_CYC = (PULL_IN_CYC > DROP_OUT_CYC) ? PULL_IN_CYC : DROP_OUT_CYC;
   localparam logic [CNT_W-1:0] PULL_W = CNT_W'(PULL_IN_CYC);
   localparam logic [CNT_W-1:0] DROP_W = CNT_W'(DROP_OUT_CYC);
   localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_CYC);

   // Last check cycle index: two cycles for the synchronizer to catch up with
   // the settled contacts, plus the cycle in which the sample is taken.
   localparam logic [1:0] CHK_LAST = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       chk_q, chk_d;
   logic [N-1:0]     coil_q, coil_d;
   logic [N-1:0]     settled_q, settled_d;
   logic             err_q, err_d;
   logic             done_q, done_d;

   logic [N-1:0]     fb_sample;
   logic             fb_err;

`ifdef RELAY_FB_CHECK_EN
   logic [N-1:0] sync1_q, sync2_q;

   // Two-flop synchronizer for the asynchronous contact feedback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= contact_fb;
         sync2_q <= sync1_q;
      end
   end

   assign fb_sample = sync2_q;
   assign fb_err    = |(sync2_q ^ coil_q);
`else
   logic unused_contact_fb;
   assign unused_contact_fb = ^contact_fb;
   assign fb_sample = coil_q;
   assign fb_err    = 1'b0;
`endif

   logic             accept;
   logic             rise_any, fall_any;
   logic [CNT_W-1:0] wait_cyc;

   assign accept   = req_valid && (state_q == S_IDLE);
   assign rise_any = |(req_coils & ~coil_q);
   assign fall_any = |(~req_coils & coil_q);

   // Settle time chosen from the direction of the coil changes
   always_comb begin
      wait_cyc = '0;
      case ({rise_any, fall_any})
         2'b10:   wait_cyc = PULL_W;
         2'b01:   wait_cyc = DROP_W;
         2'b11:   wait_cyc = MAX_W;
         default: wait_cyc = '0;
      endcase
   end

   // Transaction FSM: accept, settle, check, report
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      chk_d     = chk_q;
      coil_d    = coil_q;
      settled_d = settled_q;
      err_d     = err_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               coil_d = req_coils;
               err_d  = 1'b0;
               chk_d  = '0;
               if (wait_cyc == '0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_SETTLE;
                  cnt_d   = wait_cyc - 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_CHECK;
               chk_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_CHECK: begin
            if (chk_q == CHK_LAST) begin
               state_d   = S_IDLE;
               settled_d = fb_sample;
               err_d     = fb_err;
               done_d    = 1'b1;
            end else begin
               chk_d = chk_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset releases all coils at once and aborts any transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         chk_q     <= '0;
         coil_q    <= '0;
         settled_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         chk_q     <= chk_d;
         coil_q    <= coil_d;
         settled_q <= settled_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign coil_drv      = coil_q;
   assign settled_state = settled_q;
   assign err           = err_q;

endmodule

// File: tb/tb_relay_coil_driver.sv
// Bench for relay_coil_driver: directed table, multi-cycle corner sequences
// and randomized transactions against a behavioural model.
module tb_relay_coil_driver;

   localparam int PULL = 20;
   localparam int DROP = 12;
`ifdef RELAY_FB_CHECK_EN
   localparam bit FBC = 1'b1;
`else
   localparam bit FBC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_coils = 8'h00;
   logic [7:0] coil_drv;
   logic [7:0] contact_fb;
   logic       busy, done, err;
   logic [7:0] settled_state;
   logic [7:0] fb_mask = 8'h00;

   int total = 0;
   int bad = 0;
   logic [7:0] cur = 8'h00;

   always #5 clk = ~clk;

   // Relay bank model: contacts follow the coils, with stuck bits flipped by fb_mask
   always_comb contact_fb = coil_drv ^ fb_mask;

   relay_coil_driver #(.N(8), .PULL_IN_CYC(PULL), .DROP_OUT_CYC(DROP), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_coils(req_coils), .coil_drv(coil_drv), .contact_fb(contact_fb),
      .busy(busy), .done(done), .settled_state(settled_state), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference settle time from counting rising and falling coils
   function automatic int model_wait(input logic [7:0] old_p, input logic [7:0] new_p);
      int nr, nf;
      nr = 0; nf = 0;
      for (int b = 0; b < 8; b++) begin
         if (!old_p[b] && new_p[b]) nr++;
         if (old_p[b] && !new_p[b]) nf++;
      end
      if (nr > 0 && nf > 0) return (PULL > DROP) ? PULL : DROP;
      if (nr > 0) return PULL;
      if (nf > 0) return DROP;
      return 0;
   endfunction

   // Wait for done after the acceptance edge; returns edges counted (or -1 on timeout)
   task automatic wait_done(output int k);
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1) k = -1;
   endtask

   task automatic run_txn(input string tag, input logic [7:0] coils, input logic [7:0] mask,
                          input int exp_lat, input logic [7:0] exp_set, input logic exp_err);
      int k;
      @(negedge clk);
      chk({tag, ".ready_before"}, req_ready, 1'b1);
      req_valid = 1'b1;
      req_coils = coils;
      fb_mask   = mask;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, ".coil_drv"}, coil_drv, coils);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".ready_busy"}, req_ready, 1'b0);
      chk({tag, ".err_clr"}, err, 1'b0);
      wait_done(k);
      chk({tag, ".latency"}, k, exp_lat);
      chk({tag, ".settled"}, settled_state, exp_set);
      chk({tag, ".err"}, err, exp_err);
      chk({tag, ".ready_done"}, req_ready, 1'b1);
      @(negedge clk);
      chk({tag, ".done_pulse"}, done, 1'b0);
      cur = coils;
      $display("txn %s coils=%02h lat=%0d settled=%02h err=%0b", tag, coils, k, settled_state, err);
   endtask

   typedef struct {
      logic [7:0] coils;
      logic [7:0] mask;
      int         lat;
      logic [7:0] settled;
      logic       err;
   } vec_t;

   initial begin
      vec_t vecs[6];
      int   k, dones;
      logic [7:0] c, m, es;

      vecs[0] = '{8'h01, 8'h00, 23, 8'h01, 1'b0};
      vecs[1] = '{8'h02, 8'h00, 23, 8'h02, 1'b0};
      vecs[2] = '{8'h02, 8'h00, 3,  8'h02, 1'b0};
      vecs[3] = '{8'hFF, 8'h08, 23, FBC ? 8'hF7 : 8'hFF, FBC};
      vecs[4] = '{8'h00, 8'h00, 15, 8'h00, 1'b0};
      vecs[5] = '{8'h0F, 8'h00, 23, 8'h0F, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.coil_drv", coil_drv, 8'h00);
      chk("rst.ready", req_ready, 1'b1);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.settled", settled_state, 8'h00);
      chk("rst.err", err, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].coils, vecs[i].mask,
                 vecs[i].lat, vecs[i].settled, vecs[i].err);

      // Reset in the middle of a transaction
      @(negedge clk);
      req_valid = 1'b1; req_coils = 8'hF0; fb_mask = 8'h00;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort.coil_drv", coil_drv, 8'h00);
      chk("abort.ready", req_ready, 1'b1);
      chk("abort.busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      chk("abort.no_done", dones, 0);
      $display("txn abort coils=F0 dones_after=%0d", dones);
      cur = 8'h00;

      // req_valid held high across a busy transaction: back-to-back in order
      @(negedge clk);
      req_valid = 1'b1; req_coils = 8'h33;
      @(posedge clk);
      @(negedge clk);
      req_coils = 8'h44;
      wait_done(k);
      chk("b2b.first_lat", k, 23);
      chk("b2b.first_coil", coil_drv, 8'h33);
      chk("b2b.first_settled", settled_state, 8'h33);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b.second_coil", coil_drv, 8'h44);
      chk("b2b.done_low", done, 1'b0);
      wait_done(k);
      chk("b2b.second_lat", k, model_wait(8'h33, 8'h44) + 3);
      chk("b2b.second_settled", settled_state, 8'h44);
      $display("txn b2b coils=33->44 lat2=%0d", k);
      @(negedge clk);
      cur = 8'h44;

      // Randomized transactions against the behavioural model
      for (int i = 0; i < 40; i++) begin
         c  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) c = cur;
         m  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         es = FBC ? (c ^ m) : c;
         run_txn($sformatf("rnd%0d", i), c, m, model_wait(cur, c) + 3, es, FBC && (m != 8'h00));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
